pc_ras_unit: RTL and testbench

- Program-counter unit for the 5-phase multicycle core: f, r, x, m, w, one-hot on `phase[4:0]`, bit 0 = f, bit 4 = w.
- Parametrised successor of the basic PC register. Adds:
  - configurable PC and memory-address widths and reset vector;
  - pipeline stall;
  - link-address output;
  - circular return-address stack (RAS) that supplies return targets;
  - alignment checking on redirects.
- Sits between the control unit (branch decision) and the instruction-memory address port.

---
 rtl/pc_ras_unit.sv | 154 +++++++++++++++
 tb/tb_pc_ras_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter for the 5-phase multicycle core (f,r,x,m,w).
// Provides the fetch address, the link address and a circular return-address
// stack that supplies return targets. Redirect targets are force-aligned and
// flagged when their low bits were nonzero.
// Optional build macro PC_RAS_EXC_EN adds exception redirect (exc_req/epc).
module pc_ras_unit #(
    parameter int unsigned           XLEN      = 32,
    parameter int unsigned           MA_W      = 8,
    parameter logic [XLEN-1:0]       RESET_VEC = '0,
    parameter logic [XLEN-1:0]       INC       = 4,
    parameter int unsigned           RAS_DEPTH = 4
`ifdef PC_RAS_EXC_EN
    ,parameter logic [XLEN-1:0]      EXC_VEC   = 32'h100
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      phase,
    input  logic            stall,
    input  logic            ct_taken,
    input  logic            ct_call,
    input  logic            ct_ret,
    input  logic [XLEN-1:0] dr,
`ifdef PC_RAS_EXC_EN
    input  logic            exc_req,
    output logic [XLEN-1:0] epc,
`endif
    output logic [XLEN-1:0] pc,
    output logic [MA_W-1:0] ma,
    output logic [XLEN-1:0] link,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [MA_W-1:0] ma_q, ma_d;
    logic [XLEN-1:0] link_q, link_d;
    logic            misalign_q, misalign_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
`ifdef PC_RAS_EXC_EN
    logic [XLEN-1:0] epc_q, epc_d;
`endif

    logic [XLEN-1:0] pc_inc;
    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] target;
    logic            w_act;

    // Next-state: exception (if built) > f > taken w; stall freezes everything.
    // ptr_q points at the next free slot, so the top of stack is ptr_q-1.
    always_comb begin
        pc_d       = pc_q;
        ma_d       = ma_q;
        link_d     = link_q;
        misalign_d = misalign_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        ras_d      = ras_q;
`ifdef PC_RAS_EXC_EN
        epc_d      = epc_q;
`endif
        pc_inc  = pc_q + INC;
        top_idx = ptr_q - 1'b1;
        target  = (ct_ret && !empty_q) ? ras_q[top_idx] : dr;
        w_act   = phase[4] && !(|phase[3:1]);

        if (!stall) begin
`ifdef PC_RAS_EXC_EN
            if (exc_req) begin
                epc_d      = pc_q;
                pc_d       = EXC_VEC;
                misalign_d = 1'b0;
            end else
`endif
            if (phase[0]) begin
                ma_d       = pc_q[MA_W-1:0];
                pc_d       = pc_inc;
                link_d     = pc_inc;
                misalign_d = 1'b0;
            end else if (w_act && ct_taken) begin
                pc_d       = {target[XLEN-1:2], 2'b00};
                misalign_d = |target[1:0];
                if (ct_call && ct_ret && !empty_q) begin
                    // call+return: replace top entry, depth unchanged
                    ras_d[top_idx] = link_q;
                end else if (ct_call) begin
                    ras_d[ptr_q] = link_q;
                    ptr_d        = ptr_q + 1'b1;
                    if (count_q != DEPTH_C)
                        count_d = count_q + 1'b1;
                end else if (ct_ret && !empty_q) begin
                    ptr_d   = top_idx;
                    count_d = count_q - 1'b1;
                end
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VEC;
            ma_q       <= RESET_VEC[MA_W-1:0];
            link_q     <= '0;
            misalign_q <= 1'b0;
            ptr_q      <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++)
                ras_q[i] <= '0;
`ifdef PC_RAS_EXC_EN
            epc_q      <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            ma_q       <= ma_d;
            link_q     <= link_d;
            misalign_q <= misalign_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            ras_q      <= ras_d;
`ifdef PC_RAS_EXC_EN
            epc_q      <= epc_d;
`endif
        end
    end

    assign pc        = pc_q;
    assign ma        = ma_q;
    assign link      = link_q;
    assign misalign  = misalign_q;
    assign ras_empty = empty_q;
    assign ras_full  = full_q;
`ifdef PC_RAS_EXC_EN
    assign epc       = epc_q;
`endif

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed testbench for pc_ras_unit (default parameters).
module tb_pc_ras_unit;

    localparam logic [4:0] PF = 5'b00001;
    localparam logic [4:0] PR = 5'b00010;
    localparam logic [4:0] PX = 5'b00100;
    localparam logic [4:0] PM = 5'b01000;
    localparam logic [4:0] PW = 5'b10000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  phase = 5'b00000;
    logic        stall = 1'b0;
    logic        ct_taken = 1'b0;
    logic        ct_call = 1'b0;
    logic        ct_ret = 1'b0;
    logic [31:0] dr = '0;
    logic [31:0] pc;
    logic [7:0]  ma;
    logic [31:0] link;
    logic        ras_empty;
    logic        ras_full;
    logic        misalign;
`ifdef PC_RAS_EXC_EN
    logic        exc_req = 1'b0;
    logic [31:0] epc;
`endif

    int checks = 0;
    int failures = 0;

    pc_ras_unit dut (
        .clk(clk), .rst(rst), .phase(phase), .stall(stall),
        .ct_taken(ct_taken), .ct_call(ct_call), .ct_ret(ct_ret), .dr(dr),
`ifdef PC_RAS_EXC_EN
        .exc_req(exc_req), .epc(epc),
`endif
        .pc(pc), .ma(ma), .link(link),
        .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [4:0] ph);
        phase = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic rest_of_instr(input logic tk, input logic cl, input logic rt, input logic [31:0] d);
        step(PR);
        step(PX);
        step(PM);
        ct_taken = tk; ct_call = cl; ct_ret = rt; dr = d;
        step(PW);
        ct_taken = 1'b0; ct_call = 1'b0; ct_ret = 1'b0;
        phase = 5'b00000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ma !== 8'h0) begin failures++; $display("FAIL reset_ma got=%h exp=%h", ma, 8'h0); end
        checks++; if (link !== 32'h0) begin failures++; $display("FAIL reset_link got=%h exp=%h", link, 32'h0); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0 || misalign !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b%b exp=100", ras_empty, ras_full, misalign);
        end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_ma [3];
        exp_ma[0] = 8'h00; exp_ma[1] = 8'h04; exp_ma[2] = 8'h08;
        for (int i = 0; i < 3; i++) begin
            step(PF);
            checks++; if (ma !== exp_ma[i]) begin failures++; $display("FAIL seq_ma%0d got=%h exp=%h", i, ma, exp_ma[i]); end
            rest_of_instr(1'b0, 1'b0, 1'b0, 32'h0);
        end
        checks++; if (pc !== 32'd12) begin failures++; $display("FAIL seq_pc got=%h exp=%h", pc, 32'd12); end
        checks++; if (link !== 32'd12) begin failures++; $display("FAIL seq_link got=%h exp=%h", link, 32'd12); end
    endtask

    task automatic test_call_ret();
        step(PF);                                  // pc 0xC -> 0x10
        rest_of_instr(1'b0, 1'b0, 1'b0, 32'h0);
        step(PF);                                  // fetch at 0x10, link 0x14
        rest_of_instr(1'b1, 1'b1, 1'b0, 32'h80);
        checks++; if (pc !== 32'h80) begin failures++; $display("FAIL call_pc got=%h exp=%h", pc, 32'h80); end
        checks++; if (ras_empty !== 1'b0) begin failures++; $display("FAIL call_empty got=%b exp=0", ras_empty); end
        step(PF);
        checks++; if (ma !== 8'h80) begin failures++; $display("FAIL call_ma got=%h exp=%h", ma, 8'h80); end
        rest_of_instr(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEC);
        checks++; if (pc !== 32'h14) begin failures++; $display("FAIL ret_pc got=%h exp=%h", pc, 32'h14); end
        checks++; if (ras_empty !== 1'b1) begin failures++; $display("FAIL ret_empty got=%b exp=1", ras_empty); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_t [4];
        exp_t[0] = 32'h14; exp_t[1] = 32'h10; exp_t[2] = 32'hC; exp_t[3] = 32'h8;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(PF);
            rest_of_instr(1'b1, 1'b1, 1'b0, link);  // call to the next sequential address
            if (i == 2) begin
                checks++; if (ras_full !== 1'b0) begin failures++; $display("FAIL ovf_full3 got=%b exp=0", ras_full); end
            end
            if (i >= 3) begin
                checks++; if (ras_full !== 1'b1) begin failures++; $display("FAIL ovf_full%0d got=%b exp=1", i + 1, ras_full); end
            end
        end
        checks++; if (pc !== 32'h14) begin failures++; $display("FAIL ovf_pc got=%h exp=%h", pc, 32'h14); end
        for (int i = 0; i < 4; i++) begin
            step(PF);
            rest_of_instr(1'b1, 1'b0, 1'b1, 32'h300);
            checks++; if (pc !== exp_t[i]) begin failures++; $display("FAIL pop%0d_pc got=%h exp=%h", i, pc, exp_t[i]); end
        end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin
            failures++; $display("FAIL pop_flags got=%b%b exp=10", ras_empty, ras_full);
        end
        step(PF);
        rest_of_instr(1'b1, 1'b0, 1'b1, 32'h300);
        checks++; if (pc !== 32'h300) begin failures++; $display("FAIL pop_empty_pc got=%h exp=%h", pc, 32'h300); end
    endtask

    task automatic test_misalign();
        step(PF);
        rest_of_instr(1'b1, 1'b0, 1'b0, 32'h0000_0206);
        checks++; if (pc !== 32'h204) begin failures++; $display("FAIL mis_pc got=%h exp=%h", pc, 32'h204); end
        checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", misalign); end
        step(PF);
        checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%b exp=0", misalign); end
        checks++; if (pc !== 32'h208) begin failures++; $display("FAIL mis_next_pc got=%h exp=%h", pc, 32'h208); end
        rest_of_instr(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_stall();
        // pc=0x208, ma=0x04, link=0x208, RAS empty
        stall = 1'b1;
        step(PF);
        checks++; if (pc !== 32'h208 || ma !== 8'h04 || link !== 32'h208) begin
            failures++; $display("FAIL stall_f got=%h/%h/%h exp=00000208/04/00000208", pc, ma, link);
        end
        ct_taken = 1'b1; ct_call = 1'b1; dr = 32'h400;
        step(PW);
        checks++; if (pc !== 32'h208 || ras_empty !== 1'b1) begin
            failures++; $display("FAIL stall_w got=%h/%b exp=00000208/1", pc, ras_empty);
        end
        ct_taken = 1'b0; ct_call = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_async_reset();
        step(PF);                                   // 0x208 -> 0x20C, link 0x20C
        rest_of_instr(1'b1, 1'b1, 1'b0, 32'h500);
        checks++; if (pc !== 32'h500 || ras_empty !== 1'b0) begin
            failures++; $display("FAIL arst_pre got=%h/%b exp=00000500/0", pc, ras_empty);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || ma !== 8'h0 || link !== 32'h0) begin
            failures++; $display("FAIL arst_vals got=%h/%h/%h exp=0/0/0", pc, ma, link);
        end
        checks++; if (ras_empty !== 1'b1 || misalign !== 1'b0) begin
            failures++; $display("FAIL arst_flags got=%b%b exp=10", ras_empty, misalign);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        step(PF);
        rest_of_instr(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        step(PF);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (ma !== 8'hFC) begin failures++; $display("FAIL wrap_ma got=%h exp=%h", ma, 8'hFC); end
        checks++; if (link !== 32'h0) begin failures++; $display("FAIL wrap_link got=%h exp=%h", link, 32'h0); end
        rest_of_instr(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

`ifdef PC_RAS_EXC_EN
    task automatic test_exception();
        step(PF);
        rest_of_instr(1'b1, 1'b0, 1'b0, 32'h40);
        step(PF);
        rest_of_instr(1'b1, 1'b0, 1'b0, 32'h40);    // pc back to 0x40
        step(PR);
        step(PX);
        exc_req = 1'b1;
        step(PM);
        exc_req = 1'b0;
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL exc_pc got=%h exp=%h", pc, 32'h100); end
        checks++; if (epc !== 32'h40) begin failures++; $display("FAIL exc_epc got=%h exp=%h", epc, 32'h40); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_call_ret();
        test_ras_overflow();
        test_misalign();
        test_stall();
        test_async_reset();
        test_wrap();
`ifdef PC_RAS_EXC_EN
        test_exception();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
